// File: rtl/riscv_m_unit_core.sv
// RV32M execution unit: single-cycle registered multiplier plus a 32-step
// restoring divider, returning each result with a one-cycle ready/wr pulse.
module riscv_m_unit_core (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic [31:0] instruction,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        wr,
    output logic [31:0] rd,
    output logic        busy,
    output logic        ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    state_t      state;
    logic [2:0]  funct3_q;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [31:0] divisor;
    logic [5:0]  count;
    logic        neg_quot;
    logic        neg_rem;
    logic        pending;
    logic [31:0] special_result;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        accept;
    logic        div_signed;
    logic        div_by_zero;
    logic        div_overflow;
    logic [31:0] special_value;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        unused_bits;

    assign opcode      = instruction[6:0];
    assign funct3      = instruction[14:12];
    assign funct7      = instruction[31:25];
    assign unused_bits = ^{instruction[24:15], instruction[11:7]};

    assign accept = valid && !busy && !ready && (state == ST_IDLE) &&
                    (opcode == 7'b0110011) && (funct7 == 7'b0000001);

    // DIV and REM have funct3[0]=0; DIVU and REMU are the unsigned forms.
    assign div_signed   = !funct3[0];
    assign div_by_zero  = (rs2 == 32'h0);
    assign div_overflow = div_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

    always_comb begin
        special_value = 32'h0;
        if (div_by_zero) begin
            special_value = funct3[1] ? rs1 : 32'hFFFF_FFFF;
        end else if (div_overflow) begin
            special_value = funct3[1] ? 32'h0 : 32'h8000_0000;
        end
    end

    assign mag_a = (div_signed && rs1[31]) ? (~rs1 + 32'd1) : rs1;
    assign mag_b = (div_signed && rs2[31]) ? (~rs2 + 32'd1) : rs2;

    // Multiply: 33-bit extended operands, widened to 64 bits so the low
    // 64 bits of an unsigned product equal the signed product.
    logic        sign_a;
    logic        sign_b;
    logic [63:0] wide_a;
    logic [63:0] wide_b;
    logic [63:0] product;
    logic [31:0] mul_result;

    assign sign_a     = (funct3_q == 3'b001 || funct3_q == 3'b010) && op_a[31];
    assign sign_b     = (funct3_q == 3'b001) && op_b[31];
    assign wide_a     = {{32{sign_a}}, op_a};
    assign wide_b     = {{32{sign_b}}, op_b};
    assign product    = wide_a * wide_b;
    assign mul_result = (funct3_q[1:0] == 2'b00) ? product[31:0] : product[63:32];

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    logic [32:0] rem_shift;
    logic [32:0] trial;
    logic [31:0] quot_final;
    logic [31:0] rem_final;

    assign rem_shift  = {remainder, quotient[31]};
    assign trial      = rem_shift - {1'b0, divisor};
    assign quot_final = neg_quot ? (~quotient + 32'd1) : quotient;
    assign rem_final  = neg_rem ? (~remainder + 32'd1) : remainder;

    always_ff @(posedge clk) begin
        if (resetn) begin
            state          <= ST_IDLE;
            funct3_q       <= 3'b000;
            op_a           <= 32'h0;
            op_b           <= 32'h0;
            quotient       <= 32'h0;
            remainder      <= 32'h0;
            divisor        <= 32'h0;
            count          <= 6'd0;
            neg_quot       <= 1'b0;
            neg_rem        <= 1'b0;
            pending        <= 1'b0;
            special_result <= 32'h0;
            wr             <= 1'b0;
            rd             <= 32'h0;
            busy           <= 1'b0;
            ready          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wr    <= 1'b0;
                    ready <= 1'b0;
                    if (accept) begin
                        busy      <= 1'b1;
                        funct3_q  <= funct3;
                        op_a      <= rs1;
                        op_b      <= rs2;
                        quotient  <= mag_a;
                        remainder <= 32'h0;
                        divisor   <= mag_b;
                        count     <= 6'd0;
                        neg_quot  <= div_signed && (rs1[31] ^ rs2[31]);
                        neg_rem   <= div_signed && rs1[31];
                        if (!funct3[2]) begin
                            state <= ST_MUL;
                        end else if (div_by_zero || div_overflow) begin
                            special_result <= special_value;
                            pending        <= 1'b1;
                            state          <= ST_DONE;
                        end else begin
                            state <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    rd    <= mul_result;
                    ready <= 1'b1;
                    wr    <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_DONE;
                end
                ST_DIV: begin
                    if (count == 6'd32) begin
                        rd    <= funct3_q[1] ? rem_final : quot_final;
                        ready <= 1'b1;
                        wr    <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        if (!trial[32]) begin
                            remainder <= trial[31:0];
                            quotient  <= {quotient[30:0], 1'b1};
                        end else begin
                            remainder <= rem_shift[31:0];
                            quotient  <= {quotient[30:0], 1'b0};
                        end
                        count <= count + 6'd1;
                    end
                end
                ST_DONE: begin
                    // Special cases arrive here with the result still to be written.
                    if (pending) begin
                        pending <= 1'b0;
                        rd      <= special_result;
                        ready   <= 1'b1;
                        wr      <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        ready <= 1'b0;
                        wr    <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_m_unit_core.sv
// Scoreboard bench for riscv_m_unit_core: expected results queued at issue,
// popped and compared (value, latency, wr, busy) when ready pulses.
module tb_riscv_m_unit_core;

    logic        clk;
    logic        resetn;
    logic        valid;
    logic [31:0] instruction;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        wr;
    logic [31:0] rd;
    logic        busy;
    logic        ready;

    riscv_m_unit_core dut (
        .clk         (clk),
        .resetn      (resetn),
        .valid       (valid),
        .instruction (instruction),
        .rs1         (rs1),
        .rs2         (rs2),
        .wr          (wr),
        .rd          (rd),
        .busy        (busy),
        .ready       (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] expected;
        int          latency;
    } expect_t;

    expect_t     scoreboard[$];
    int          checks;
    int          failures;
    int          cyc;
    int          acceptCyc;
    logic        prevReady;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, expected);
        end
    endtask

    function automatic logic [31:0] mInsn(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // Monitor: every ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ready) begin
            checkOutput("ready_not_repeated", {31'b0, prevReady}, 32'h0);
            if (scoreboard.size() == 0) begin
                checkOutput("unexpected_ready", 32'h1, 32'h0);
            end else begin
                expect_t e;
                e = scoreboard.pop_front();
                checkOutput(e.tag, rd, e.expected);
                checkOutput({e.tag, "_latency"}, 32'(cyc - acceptCyc), 32'(e.latency));
                checkOutput({e.tag, "_wr"}, {31'b0, wr}, 32'h1);
                checkOutput({e.tag, "_busy_low"}, {31'b0, busy}, 32'h0);
            end
        end
        prevReady <= ready;
    end

    task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expected,
                                 input int latency, input bit injectValid);
        int n;
        @(negedge clk);
        valid       = 1'b1;
        instruction = mInsn(f3);
        rs1         = a;
        rs2         = b;
        scoreboard.push_back('{tag, expected, latency});
        @(negedge clk);
        valid     = 1'b0;
        acceptCyc = cyc;
        checkOutput({tag, "_busy"}, {31'b0, busy}, 32'h1);
        n = 0;
        while (!ready && n < 60) begin
            if (injectValid && n == 3) begin
                valid       = 1'b1;
                instruction = mInsn(3'b000);
                rs1         = 32'd7;
                rs2         = 32'd9;
            end else begin
                valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        valid = 1'b0;
        if (!ready) checkOutput({tag, "_timeout"}, 32'h1, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout got=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        cyc         = 0;
        acceptCyc   = 0;
        prevReady   = 1'b0;
        valid       = 1'b0;
        instruction = 32'h0;
        rs1         = 32'h0;
        rs2         = 32'h0;
        resetn      = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_wr", {31'b0, wr}, 32'h0);
        checkOutput("reset_rd", rd, 32'h0);
        checkOutput("reset_busy", {31'b0, busy}, 32'h0);
        checkOutput("reset_ready", {31'b0, ready}, 32'h0);
        resetn = 1'b0;
        @(negedge clk);

        applyStimulus("mul",        3'b000, 32'h1111FFFF, 32'h1111FFFF, 32'hDDDC0001, 1, 0);
        applyStimulus("mulhu",      3'b011, 32'h1111FFFF, 32'h1111FFFF, 32'h01236543, 1, 0);
        applyStimulus("mulh_neg",   3'b001, 32'hFFFFFFFB, 32'hFFFFFFFC, 32'h00000000, 1, 0);
        applyStimulus("mulh_m1",    3'b001, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
        applyStimulus("mulhsu",     3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
        applyStimulus("mulhu_max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 0);
        applyStimulus("div_neg",    3'b100, 32'hFFFFFFF3, 32'd5,        32'hFFFFFFFE, 33, 0);
        applyStimulus("rem_neg",    3'b110, 32'hFFFFFFF3, 32'd5,        32'hFFFFFFFD, 33, 0);
        applyStimulus("div_both",   3'b100, -32'sd34,     -32'sd23,     32'h00000001, 33, 1);
        applyStimulus("rem_small",  3'b110, 32'hFFFFFF30, 32'h00003001, 32'hFFFFFF30, 33, 0);
        applyStimulus("divu",       3'b101, 32'd100,      32'd7,        32'd14,       33, 0);
        applyStimulus("remu",       3'b111, 32'd100,      32'd7,        32'd2,        33, 1);
        applyStimulus("divu_max",   3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, 0);
        applyStimulus("divu_zero",  3'b101, 32'd13,       32'd0,        32'hFFFFFFFF, 1, 0);
        applyStimulus("remu_zero",  3'b111, 32'd13,       32'd0,        32'd13,       1, 0);
        applyStimulus("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        applyStimulus("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0);

        // A non-M R-type instruction must not start anything.
        @(negedge clk);
        valid       = 1'b1;
        instruction = 32'h00000033;
        rs1         = 32'd3;
        rs2         = 32'd4;
        @(negedge clk);
        valid = 1'b0;
        checkOutput("non_m_busy", {31'b0, busy}, 32'h0);
        repeat (4) @(negedge clk);
        checkOutput("non_m_ready", {31'b0, ready}, 32'h0);

        // Reset in the middle of a divide aborts it without a ready pulse.
        @(negedge clk);
        valid       = 1'b1;
        instruction = mInsn(3'b101);
        rs1         = 32'd1000;
        rs2         = 32'd3;
        @(negedge clk);
        valid = 1'b0;
        checkOutput("abort_busy_before", {31'b0, busy}, 32'h1);
        repeat (10) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        checkOutput("abort_busy", {31'b0, busy}, 32'h0);
        checkOutput("abort_rd", rd, 32'h0);
        checkOutput("abort_ready", {31'b0, ready}, 32'h0);
        repeat (40) @(negedge clk);

        applyStimulus("mul_after_abort", 3'b000, 32'd6, 32'd7, 32'd42, 1, 0);
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
